// File: rtl/mem_lsu_stage.sv
// Memory-access pipeline stage between EXE and MEM_WB.
// Non-memory results pass through with one registered cycle. Loads and stores
// run a req/ack data-bus handshake with sizing, load extension, misalignment
// detection and an ack timeout. EXE is stalled while a bus access is open.
module mem_lsu_stage #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i_LSU,
  input  logic                  rst_i_LSU,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            mem_op_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [DATA_W-1:0]     alu_result_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic [REG_ADDR_W-1:0] wt_addr_i,
  input  logic                  wt_en_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_W-1:0]     dmem_addr_o,
  output logic [DATA_W-1:0]     dmem_wdata_o,
  output logic [DATA_W/8-1:0]   dmem_strb_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_W-1:0]     dmem_rdata_i,
  output logic                  wb_valid_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic [REG_ADDR_W-1:0] wb_addr_o,
  output logic                  wb_en_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_ACK = 1'b1;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  logic [0:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [1:0]            size_reg;
  logic                  unsigned_reg;
  logic                  load_reg;
  logic [OFF_W-1:0]      off_reg;
  logic [REG_ADDR_W-1:0] wt_addr_reg;
  logic                  wt_en_reg;

  logic [ADDR_W-1:0] eff_addr;
  logic [1:0]        eff_size;
  logic [OFF_W-1:0]  lane_off;
  logic              is_mem;
  logic              misaligned;
  logic [STRB_W-1:0] strb_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] load_shifted;
  logic [DATA_W-1:0] load_ext;

  assign in_ready_o = (state_reg == IDLE);

  // The effective address lives in the low bits of the ALU result.
  generate
    if (ADDR_W <= DATA_W) begin : g_addr_narrow
      assign eff_addr = alu_result_i[ADDR_W-1:0];
    end else begin : g_addr_wide
      assign eff_addr = {{(ADDR_W - DATA_W){1'b0}}, alu_result_i};
    end
  endgenerate

  // A double request on a 32-bit bus degrades to a word access.
  assign eff_size = (size_i == 2'b11 && DATA_W != 64) ? SZ_WORD : size_i;
  assign lane_off = eff_addr[OFF_W-1:0];
  assign is_mem   = (mem_op_i == OP_LOAD) || (mem_op_i == OP_STORE);

  // Alignment rule and byte enables derived from the access size.
  always_comb begin
    misaligned = 1'b0;
    strb_next  = '1;
    case (eff_size)
      SZ_BYTE: strb_next = STRB_W'(1'b1) << lane_off;
      SZ_HALF: begin
        misaligned = eff_addr[0];
        strb_next  = STRB_W'(2'b11) << lane_off;
      end
      SZ_WORD: begin
        misaligned = |eff_addr[1:0];
        strb_next  = STRB_W'(4'hF) << lane_off;
      end
      default: misaligned = |eff_addr[2:0];
    endcase
  end

  // Store data is replicated so every lane carries the bytes it may write.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_wlane
      always_comb begin
        case (eff_size)
          SZ_BYTE: wdata_next[8*gi +: 8] = store_data_i[7:0];
          SZ_HALF: wdata_next[8*gi +: 8] = store_data_i[8*(gi % 2) +: 8];
          SZ_WORD: wdata_next[8*gi +: 8] = store_data_i[8*(gi % 4) +: 8];
          default: wdata_next[8*gi +: 8] = store_data_i[8*gi +: 8];
        endcase
      end
    end
  endgenerate

  assign load_shifted = dmem_rdata_i >> {off_reg, 3'b000};

  // Truncate the shifted read data to the access size and extend it.
  always_comb begin
    int  top_bit;
    logic fill;
    case (size_reg)
      SZ_BYTE: top_bit = 7;
      SZ_HALF: top_bit = 15;
      SZ_WORD: top_bit = 31;
      default: top_bit = DATA_W - 1;
    endcase
    fill     = ~unsigned_reg & load_shifted[top_bit];
    load_ext = load_shifted;
    for (int i = 0; i < DATA_W; i++) begin
      if (i > top_bit) load_ext[i] = fill;
    end
  end

  // Stage control: accept in IDLE, hold the bus request until ack or timeout.
  always_ff @(posedge clk_i_LSU) begin
    if (rst_i_LSU) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      size_reg     <= '0;
      unsigned_reg <= 1'b0;
      load_reg     <= 1'b0;
      off_reg      <= '0;
      wt_addr_reg  <= '0;
      wt_en_reg    <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_strb_o  <= '0;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= '0;
      wb_addr_o    <= '0;
      wb_en_o      <= 1'b0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid_i) begin
            if (!is_mem) begin
              wb_valid_o <= 1'b1;
              wb_data_o  <= alu_result_i;
              wb_addr_o  <= wt_addr_i;
              wb_en_o    <= wt_en_i;
            end else if (misaligned) begin
              wb_valid_o <= 1'b1;
              misalign_o <= 1'b1;
              wb_data_o  <= '0;
              wb_addr_o  <= wt_addr_i;
              wb_en_o    <= 1'b0;
            end else begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= (mem_op_i == OP_STORE);
              dmem_addr_o  <= {eff_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              dmem_wdata_o <= wdata_next;
              dmem_strb_o  <= strb_next;
              state_reg    <= WAIT_ACK;
              cnt_reg      <= '0;
              size_reg     <= eff_size;
              unsigned_reg <= unsigned_i;
              load_reg     <= (mem_op_i == OP_LOAD);
              off_reg      <= lane_off;
              wt_addr_reg  <= wt_addr_i;
              wt_en_reg    <= wt_en_i;
            end
          end
        end
        WAIT_ACK: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            state_reg  <= IDLE;
            wb_valid_o <= 1'b1;
            wb_addr_o  <= wt_addr_reg;
            wb_en_o    <= load_reg & wt_en_reg;
            wb_data_o  <= load_reg ? load_ext : '0;
          end else if (cnt_reg == CNT_LIMIT) begin
            dmem_req_o <= 1'b0;
            state_reg  <= IDLE;
            bus_err_o  <= 1'b1;
            wb_valid_o <= 1'b1;
            wb_addr_o  <= wt_addr_reg;
            wb_en_o    <= 1'b0;
            wb_data_o  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Randomized self-checking bench for mem_lsu_stage (64-bit bus, TIMEOUT=4).
module tb_mem_lsu_stage;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid_i, in_ready_o;
  logic [1:0]    mem_op_i, size_i;
  logic          unsigned_i;
  logic [DW-1:0] alu_result_i, store_data_i;
  logic [RW-1:0] wt_addr_i;
  logic          wt_en_i;
  logic          dmem_req_o, dmem_we_o;
  logic [AW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o;
  logic [7:0]    dmem_strb_o;
  logic          dmem_ack_i;
  logic [DW-1:0] dmem_rdata_i;
  logic          wb_valid_o;
  logic [DW-1:0] wb_data_o;
  logic [RW-1:0] wb_addr_o;
  logic          wb_en_o, misalign_o, bus_err_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_lsu_stage #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW), .TIMEOUT(TO)) dut (
    .clk_i_LSU(clk), .rst_i_LSU(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mem_op_i(mem_op_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .wt_addr_i(wt_addr_i), .wt_en_i(wt_en_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_strb_o(dmem_strb_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o),
    .wb_en_o(wb_en_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with a stray ack that the stage must ignore.
  task automatic idle_cycle();
    in_valid_i = 1'b0;
    dmem_ack_i = 1'($urandom % 2);
    step();
    dmem_ack_i = 1'b0;
    check_val("idle_wb_valid", wb_valid_o, 0);
    check_val("idle_req", dmem_req_o, 0);
    check_val("idle_ready", in_ready_o, 1);
    check_val("idle_flags", {misalign_o, bus_err_o}, 0);
  endtask

  task automatic accept(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [63:0] sd,
                        input logic [4:0] wa, input logic we_en);
    check_val("accept_ready", in_ready_o, 1);
    in_valid_i   = 1'b1;
    mem_op_i     = op;
    size_i       = sz;
    unsigned_i   = uns;
    alu_result_i = {32'h0, addr};
    store_data_i = sd;
    wt_addr_i    = wa;
    wt_en_i      = we_en;
    step();
    in_valid_i   = 1'b0;
    mem_op_i     = 2'($urandom);
    alu_result_i = {$urandom, $urandom};
    store_data_i = {$urandom, $urandom};
  endtask

  // One instruction end-to-end; expectations come from the size/offset rules.
  task automatic do_txn(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [63:0] sd,
                        input logic [4:0] wa, input logic we_en,
                        input int ack_delay, input logic [63:0] rd);
    int          nbytes, o;
    logic        is_mem, mis, acked;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata, e_load, mask;
    logic [31:0] e_addr;
    is_mem = (op == 2'b01) || (op == 2'b10);
    nbytes = 1 << sz;
    o      = int'(addr % 8);
    mis    = is_mem && ((addr % nbytes) != 0);
    e_addr = addr - 32'(o);
    for (int k = 0; k < 8; k++) begin
      e_strb[k]        = (k >= o) && (k < o + nbytes);
      e_wdata[8*k +: 8] = sd[8*(k % nbytes) +: 8];
    end
    e_load = rd >> (8 * o);
    if (nbytes < 8) begin
      mask   = (64'd1 << (8 * nbytes)) - 64'd1;
      e_load = e_load & mask;
      if (!uns && e_load[8*nbytes-1]) e_load = e_load | ~mask;
    end

    accept(op, sz, uns, addr, sd, wa, we_en);

    if (!is_mem) begin
      check_val("none_valid", wb_valid_o, 1);
      check_val("none_data", wb_data_o, {32'h0, addr});
      check_val("none_addr", wb_addr_o, wa);
      check_val("none_en", wb_en_o, we_en);
      check_val("none_req", dmem_req_o, 0);
      check_val("none_flags", {misalign_o, bus_err_o}, 0);
    end else if (mis) begin
      check_val("mis_flag", misalign_o, 1);
      check_val("mis_valid", wb_valid_o, 1);
      check_val("mis_en", wb_en_o, 0);
      check_val("mis_data", wb_data_o, 0);
      check_val("mis_req", dmem_req_o, 0);
      check_val("mis_ready", in_ready_o, 1);
    end else begin
      acked = 1'b0;
      for (int k = 0; k < TO; k++) begin
        check_val("wait_req", dmem_req_o, 1);
        check_val("wait_ready", in_ready_o, 0);
        check_val("wait_wb_valid", wb_valid_o, 0);
        check_val("req_addr", dmem_addr_o, e_addr);
        check_val("req_strb", dmem_strb_o, e_strb);
        check_val("req_we", dmem_we_o, op == 2'b10);
        if (op == 2'b10) check_val("req_wdata", dmem_wdata_o, e_wdata);
        if (k == ack_delay) begin
          dmem_ack_i   = 1'b1;
          dmem_rdata_i = rd;
        end
        step();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = {$urandom, $urandom};
        if (k == ack_delay) begin
          acked = 1'b1;
          break;
        end
      end
      check_val("done_req", dmem_req_o, 0);
      check_val("done_valid", wb_valid_o, 1);
      check_val("done_ready", in_ready_o, 1);
      check_val("done_misalign", misalign_o, 0);
      if (acked) begin
        check_val("ack_bus_err", bus_err_o, 0);
        if (op == 2'b01) begin
          check_val("load_data", wb_data_o, e_load);
          check_val("load_en", wb_en_o, we_en);
          check_val("load_addr", wb_addr_o, wa);
        end else begin
          check_val("store_en", wb_en_o, 0);
          check_val("store_data", wb_data_o, 0);
        end
      end else begin
        check_val("timeout_bus_err", bus_err_o, 1);
        check_val("timeout_en", wb_en_o, 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op, sz;
    logic [31:0] addr;
    logic [63:0] rd;
    rst          = 1'b1;
    in_valid_i   = 1'b0;
    mem_op_i     = 2'b00;
    size_i       = 2'b00;
    unsigned_i   = 1'b0;
    alu_result_i = '0;
    store_data_i = '0;
    wt_addr_i    = '0;
    wt_en_i      = 1'b0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = '0;
    step();
    step();
    check_val("rst_req", dmem_req_o, 0);
    check_val("rst_bus", {dmem_we_o, dmem_addr_o, dmem_strb_o}, 0);
    check_val("rst_wdata", dmem_wdata_o, 0);
    check_val("rst_wb", {wb_valid_o, wb_addr_o, wb_en_o, misalign_o, bus_err_o}, 0);
    check_val("rst_wb_data", wb_data_o, 0);
    check_val("rst_ready", in_ready_o, 1);
    rst = 1'b0;

    // Directed cases.
    do_txn(2'b00, 2'b10, 1'b0, 32'h1234_5678, 64'h0, 5'd5, 1'b1, 0, 64'h0);
    do_txn(2'b01, 2'b00, 1'b0, 32'h0000_1003, 64'h0, 5'd7, 1'b1, 2, 64'h0000_0000_80AA_BBCC);
    do_txn(2'b01, 2'b00, 1'b1, 32'h0000_1003, 64'h0, 5'd7, 1'b1, 2, 64'h0000_0000_80AA_BBCC);
    do_txn(2'b10, 2'b01, 1'b0, 32'h0000_2002, 64'h0000_BEEF, 5'd1, 1'b1, 0, 64'h0);
    do_txn(2'b01, 2'b10, 1'b0, 32'h0000_3001, 64'h0, 5'd3, 1'b1, 0, 64'h0);
    do_txn(2'b01, 2'b10, 1'b0, 32'h0000_4000, 64'h0, 5'd3, 1'b1, 99, 64'h0);
    do_txn(2'b00, 2'b00, 1'b0, 32'hCAFE_0001, 64'h0, 5'd9, 1'b1, 0, 64'h0);
    do_txn(2'b01, 2'b10, 1'b0, 32'h0000_5004, 64'h0, 5'd2, 1'b1, TO - 1, 64'h8765_4321_F000_0000);
    do_txn(2'b01, 2'b11, 1'b0, 32'h0000_0008, 64'h0, 5'd4, 1'b1, 1, 64'hDEAD_BEEF_0123_4567);
    do_txn(2'b11, 2'b00, 1'b0, 32'h0000_0ABC, 64'h0, 5'd6, 1'b0, 0, 64'h0);

    // Reset on the second WAIT_ACK cycle abandons the access.
    accept(2'b01, 2'b10, 1'b0, 32'h0000_6000, 64'h0, 5'd8, 1'b1);
    check_val("rstw_req1", dmem_req_o, 1);
    step();
    check_val("rstw_req2", dmem_req_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rstw_req", dmem_req_o, 0);
    check_val("rstw_addr", dmem_addr_o, 0);
    check_val("rstw_wb", {wb_valid_o, wb_en_o, misalign_o, bus_err_o}, 0);
    check_val("rstw_ready", in_ready_o, 1);
    step();
    check_val("rstw_no_wb", wb_valid_o, 0);
    check_val("rstw_req_after", dmem_req_o, 0);

    // Randomized traffic, back-to-back when no gap is drawn.
    for (int t = 0; t < 300; t++) begin
      op   = 2'($urandom);
      sz   = 2'($urandom);
      addr = $urandom;
      if ($urandom % 2 == 0) addr = addr & ~32'h7;
      rd   = {$urandom, $urandom};
      do_txn(op, sz, 1'($urandom), addr, {$urandom, $urandom}, 5'($urandom),
             1'($urandom), int'($urandom_range(0, 5)), rd);
      if ($urandom % 3 == 0) idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu_stage.md
# mem_lsu_stage

Parametrised memory-access pipeline stage between EXE and MEM_WB that replaces the pass-through MEM stage. Non-memory results still flow through with one registered cycle. Loads and stores go through a request/acknowledge data-bus handshake with byte/half/word(/double) sizing, load sign/zero extension, misalignment detection and an ack timeout. The stage stalls EXE while a bus transaction is outstanding and drives the MEM_WB and forwarding paths from registered outputs.

## Interface
- DATA_W, 32, register/bus data width; legal values are 32 and 64.
- ADDR_W, 32, byte address width.
- REG_ADDR_W, 5, register-file address width.
- TIMEOUT, 16, maximum wait cycles for dmem_ack_i; must be ≥1.
- clk_i_LSU  in  1  clock; all state changes on the rising edge.
- rst_i_LSU  in  1  synchronous, active-high reset.
- in_valid_i  in  1  EXE presents an instruction.
- in_ready_o  out  1  stage accepts; combinational: high iff state==IDLE.
- mem_op_i  in  2  00 none, 01 load, 10 store, 11 treated as none.
- size_i  in  2  00 byte, 01 half, 10 word, 11 double (DATA_W=64 only; otherwise treated as word).
- unsigned_i  in  1  zero-extend load data when 1.
- alu_result_i  in  DATA_W  effective address (mem op) or writeback data (none).
- store_data_i  in  DATA_W  rs2 value for stores.
- wt_addr_i / wt_en_i  in  REG_ADDR_W / 1  destination register and write enable.
- dmem_req_o  out  1  bus request, registered.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  ADDR_W  address aligned down to DATA_W/8 bytes.
- dmem_wdata_o  out  DATA_W  store data replicated across lanes.
- dmem_strb_o  out  DATA_W/8  byte enables.
- dmem_ack_i  in  1  bus completes the request this cycle.
- dmem_rdata_i  in  DATA_W  read data, valid with ack.
- wb_valid_o  out  1  one-cycle pulse: result to MEM_WB.
- wb_data_o / wb_addr_o / wb_en_o  out  DATA_W / REG_ADDR_W / 1  writeback triple, also used for forwarding.
- misalign_o  out  1  one-cycle pulse, misaligned access.
- bus_err_o  out  1  one-cycle pulse, ack timeout.

## Operation
- States: IDLE, WAIT_ACK.
- Accept = in_valid_i & in_ready_o. Latch op, size, unsigned, address low bits, wt_addr, wt_en.
- None op accepted: next cycle wb_valid_o=1, wb_data_o=alu_result_i, wb_addr_o/wb_en_o from inputs; stay IDLE.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0. A misaligned load or store issues no request. Next cycle: misalign_o=1, wb_valid_o=1, wb_en_o=0, wb_data_o=0. Stay IDLE.
- Aligned load or store: next cycle dmem_req_o=1 with addr/we/wdata/strb; go to WAIT_ACK. The timeout counter is cleared.
- Lane offset o = addr mod (DATA_W/8). Strobes: byte 1<<o, half 3<<o, word 0xF<<o, double all ones.
- Write data replication: byte to every byte lane, half to every half lane, word to every word lane.
- WAIT_ACK with ack: drop req on the next edge and return to IDLE. Next cycle wb_valid_o=1.
  - Load: wb_data_o = rdata >> (8·o), truncated to the access size, then sign- or zero-extended; wb_en_o = latched wt_en.
  - Store: wb_en_o=0, wb_data_o=0.
- WAIT_ACK without ack: the counter increments. If the counter reaches TIMEOUT-1 and ack is still low, drop req and return to IDLE. Next cycle bus_err_o=1, wb_valid_o=1, wb_en_o=0.
- Ack in the same cycle the counter hits the limit counts as success.
- dmem_ack_i is ignored in IDLE.

## Timing
- Reset (at an edge with rst_i_LSU=1): state=IDLE, counter=0. All registered outputs are 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_strb_o, wb_valid_o, wb_data_o, wb_addr_o, wb_en_o, misalign_o, bus_err_o.
- Reset during WAIT_ACK abandons the access: req is low from the cycle after the reset edge, and no wb_valid_o is produced.
- Latency:
  - None op: accept at cycle N, wb_valid_o at N+1.
  - Memory op: req rises at N+1. With ack at cycle A ≥ N+1, wb_valid_o at A+1 and in_ready_o high from A+1.
  - Zero-wait bus (ack at N+1): a memory op every 2 cycles. A none op can be accepted at N+2.
- Request fields are stable while dmem_req_o=1.
- Back-to-back none ops sustain 1 per cycle.

## Test plan
- None op: alu_result=0x1234_5678, wt_addr=5, wt_en=1, accepted at cycle 0 -> cycle 1: wb_valid=1, wb_data=0x1234_5678, wb_addr=5, wb_en=1, dmem_req=0.
- Load byte signed at 0x1003, rdata=0x80AA_BBCC, ack 3 cycles after req -> strb=0x8, addr=0x1000, in_ready low for 3 cycles, wb_data=0xFFFF_FF80. Repeat with unsigned_i=1 -> 0x0000_0080.
- Store half at 0x2002, store_data=0x0000_BEEF, immediate ack -> strb=0xC, wdata=0xBEEF_BEEF, we=1, wb_valid with wb_en=0.
- Load word at 0x3001 -> no dmem_req, misalign_o=1 and wb_valid=1 with wb_en=0 next cycle, in_ready stays high.
- TIMEOUT=4, ack never asserted -> req high for exactly 4 cycles, then bus_err_o pulse with wb_valid=1, wb_en=0; next instruction is accepted.
- Reset asserted on the second WAIT_ACK cycle -> req=0 and all outputs 0 after the edge, no wb_valid; DATA_W=64 double load at 0x8 returns the full rdata.
